// File: rtl/knn_vote_decoder.sv
// Majority-vote decoder for the sorter's packed top-5 neighbour list.
// Walks ranks 1..K one per cycle, tallies four class counters, nearest neighbour breaks ties.
module knn_vote_decoder #(
    parameter int K = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [99:0]  sorted_list,
    output logic [1:0]   result_class,
    output logic [2:0]   vote_count,
    output logic         no_match,
    output logic         result_valid,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DECIDE
    } state_t;

    localparam logic [2:0]  LAST_RANK = 3'(K - 1);
    localparam logic [17:0] EMPTY_DIST = 18'h3FFFF;

    state_t       state_reg, state_next;
    logic [99:0]  shadow_reg;
    logic [2:0]   rank_idx_reg, rank_idx_next;
    logic [1:0]   result_class_reg, result_class_next;
    logic [2:0]   vote_count_reg, vote_count_next;
    logic         no_match_reg, no_match_next;
    logic         result_valid_reg, result_valid_next;

    logic         load;
    logic         counting;
    logic [19:0]  rank_entry [5];
    logic [19:0]  cur_entry;
    logic         cur_valid;
    logic [1:0]   cur_class;

    // Per-class tallies flattened so each class slice has exactly one driver.
    logic [11:0]  cnt_flat;
    logic [11:0]  first_flat;

    logic [2:0]   best_cnt;
    logic [2:0]   best_first;
    logic [1:0]   best_class;
    logic [2:0]   cand_cnt;
    logic [2:0]   cand_first;

    assign load     = (state_reg == IDLE) && start;
    assign counting = (state_reg == COUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_reg <= '0;
        end else if (load) begin
            shadow_reg <= sorted_list;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_rank
            assign rank_entry[gi] = shadow_reg[20*gi +: 20];
        end
    endgenerate

    assign cur_entry = rank_entry[rank_idx_reg];
    assign cur_valid = (cur_entry[19:2] != EMPTY_DIST);
    assign cur_class = cur_entry[1:0];

    generate
        for (gi = 0; gi < 4; gi++) begin : g_class
            logic [2:0] cnt_reg;
            logic [2:0] first_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg   <= '0;
                    first_reg <= '0;
                end else if (load) begin
                    cnt_reg   <= '0;
                    first_reg <= '0;
                end else if (counting && cur_valid && (cur_class == 2'(gi))) begin
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg == 3'd0) begin
                        first_reg <= rank_idx_reg;
                    end
                end
            end

            assign cnt_flat[3*gi +: 3]   = cnt_reg;
            assign first_flat[3*gi +: 3] = first_reg;
        end
    endgenerate

    // A class replaces the incumbent on a strictly higher count, or on an equal
    // non-zero count when it owns a nearer neighbour.
    always_comb begin
        best_cnt   = 3'd0;
        best_first = 3'd7;
        best_class = 2'd0;
        cand_cnt   = 3'd0;
        cand_first = 3'd0;
        for (int i = 0; i < 4; i++) begin
            cand_cnt   = cnt_flat[3*i +: 3];
            cand_first = first_flat[3*i +: 3];
            if ((cand_cnt > best_cnt) ||
                ((cand_cnt != 3'd0) && (cand_cnt == best_cnt) && (cand_first < best_first))) begin
                best_cnt   = cand_cnt;
                best_first = cand_first;
                best_class = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            rank_idx_reg     <= '0;
            result_class_reg <= '0;
            vote_count_reg   <= '0;
            no_match_reg     <= 1'b0;
            result_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            rank_idx_reg     <= rank_idx_next;
            result_class_reg <= result_class_next;
            vote_count_reg   <= vote_count_next;
            no_match_reg     <= no_match_next;
            result_valid_reg <= result_valid_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        rank_idx_next     = rank_idx_reg;
        result_class_next = result_class_reg;
        vote_count_next   = vote_count_reg;
        no_match_next     = no_match_reg;
        result_valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = COUNT;
                    rank_idx_next = 3'd0;
                end
            end
            COUNT: begin
                if (rank_idx_reg == LAST_RANK) begin
                    state_next = DECIDE;
                end else begin
                    rank_idx_next = rank_idx_reg + 3'd1;
                end
            end
            DECIDE: begin
                result_class_next = best_class;
                vote_count_next   = best_cnt;
                no_match_next     = (best_cnt == 3'd0);
                result_valid_next = 1'b1;
                state_next        = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign result_class = result_class_reg;
    assign vote_count   = vote_count_reg;
    assign no_match     = no_match_reg;
    assign result_valid = result_valid_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_knn_vote_decoder.sv
// Bench for knn_vote_decoder: K=5 and K=3 instances share stimulus and are checked
// every cycle against a vote-counting model, plus directed literal cases.
module tb_knn_vote_decoder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [99:0]  sorted_list = '0;

    logic [1:0]   rc5, rc3;
    logic [2:0]   vc5, vc3;
    logic         nm5, nm3, rv5, rv3, b5, b3;

    int checks = 0;
    int passes = 0;
    bit chk_on = 1'b0;

    int tc [5];
    int td [5];

    // model state per instance: index 0 is K=5, index 1 is K=3
    int kv [2] = '{5, 3};
    int cd [2] = '{0, 0};
    int e_cls [2] = '{0, 0};
    int e_cnt [2] = '{0, 0};
    int e_nm [2] = '{0, 0};
    int e_rv [2] = '{0, 0};
    int p_cls [2] = '{0, 0};
    int p_cnt [2] = '{0, 0};
    int p_nm [2] = '{0, 0};

    int lat5, lat3;
    int cap_cls5, cap_cnt5, cap_nm5, cap_cls3, cap_cnt3, cap_nm3;

    always #5 clk = ~clk;

    knn_vote_decoder #(.K(5)) dut5 (
        .clk(clk), .rst(rst), .start(start), .sorted_list(sorted_list),
        .result_class(rc5), .vote_count(vc5), .no_match(nm5),
        .result_valid(rv5), .busy(b5)
    );

    knn_vote_decoder #(.K(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .sorted_list(sorted_list),
        .result_class(rc3), .vote_count(vc3), .no_match(nm3),
        .result_valid(rv3), .busy(b3)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [99:0] pack_tc();
        logic [99:0] l;
        l = '0;
        for (int r = 0; r < 5; r++) l[20*r +: 20] = {18'(td[r]), 2'(tc[r])};
        return l;
    endfunction

    // Tally votes, find the top count, then the winner is the class of the
    // nearest valid rank whose class reaches that count.
    task automatic ref_decode(input logic [99:0] l, input int k,
                              output int cls, output int cnt, output int nm);
        int votes [4];
        int m;
        bit found;
        votes = '{0, 0, 0, 0};
        m = 0;
        found = 1'b0;
        for (int r = 0; r < k; r++)
            if (l[20*r+2 +: 18] != 18'h3FFFF) votes[l[20*r +: 2]]++;
        for (int c = 0; c < 4; c++) if (votes[c] > m) m = votes[c];
        cls = 0;
        cnt = m;
        nm = (m == 0) ? 1 : 0;
        for (int r = 0; r < k; r++) begin
            if (!found && m > 0 && l[20*r+2 +: 18] != 18'h3FFFF && votes[l[20*r +: 2]] == m) begin
                cls = int'(l[20*r +: 2]);
                found = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                cd[u] = 0; e_rv[u] = 0; e_cls[u] = 0; e_cnt[u] = 0; e_nm[u] = 0;
            end else begin
                e_rv[u] = 0;
                if (cd[u] > 0) begin
                    cd[u]--;
                    if (cd[u] == 0) begin
                        e_rv[u] = 1; e_cls[u] = p_cls[u]; e_cnt[u] = p_cnt[u]; e_nm[u] = p_nm[u];
                    end
                end else if (start) begin
                    ref_decode(sorted_list, kv[u], p_cls[u], p_cnt[u], p_nm[u]);
                    cd[u] = kv[u] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("k5 result_valid", int'(rv5), e_rv[0]);
            chk("k5 busy", int'(b5), (cd[0] > 0) ? 1 : 0);
            chk("k5 result_class", int'(rc5), e_cls[0]);
            chk("k5 vote_count", int'(vc5), e_cnt[0]);
            chk("k5 no_match", int'(nm5), e_nm[0]);
            chk("k3 result_valid", int'(rv3), e_rv[1]);
            chk("k3 busy", int'(b3), (cd[1] > 0) ? 1 : 0);
            chk("k3 result_class", int'(rc3), e_cls[1]);
            chk("k3 vote_count", int'(vc3), e_cnt[1]);
            chk("k3 no_match", int'(nm3), e_nm[1]);
        end
    end

    task automatic run_one(input logic [99:0] l);
        @(negedge clk);
        sorted_list = l;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat5 = -1;
        lat3 = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (rv3 && lat3 < 0) begin
                lat3 = n; cap_cls3 = int'(rc3); cap_cnt3 = int'(vc3); cap_nm3 = int'(nm3);
            end
            if (rv5 && lat5 < 0) begin
                lat5 = n; cap_cls5 = int'(rc5); cap_cnt5 = int'(vc5); cap_nm5 = int'(nm5);
            end
            if (lat5 >= 0 && lat3 >= 0) break;
        end
    endtask

    task automatic check_pair(input string tag, input int c5, input int n5, input int m5,
                              input int c3, input int n3, input int m3);
        chk({tag, " k5 latency"}, lat5, 6);
        chk({tag, " k3 latency"}, lat3, 4);
        chk({tag, " k5 class"}, cap_cls5, c5);
        chk({tag, " k5 count"}, cap_cnt5, n5);
        chk({tag, " k5 no_match"}, cap_nm5, m5);
        chk({tag, " k3 class"}, cap_cls3, c3);
        chk({tag, " k3 count"}, cap_cnt3, n3);
        chk({tag, " k3 no_match"}, cap_nm3, m3);
    endtask

    initial begin
        logic [99:0] la, lb;
        int mc, mn, mm;
        int seen;

        @(posedge clk);
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset result_valid", int'(rv5), 0);
        chk("reset busy", int'(b5), 0);
        chk("reset result_class", int'(rc5), 0);
        chk("reset vote_count", int'(vc5), 0);
        chk("reset no_match", int'(nm5), 0);
        @(negedge clk);
        rst = 1'b0;

        // majority: 2,2,1,3,2
        tc = '{2, 2, 1, 3, 2}; td = '{10, 20, 30, 40, 50};
        la = pack_tc();
        ref_decode(la, 5, mc, mn, mm);
        chk("model majority class", mc, 2);
        chk("model majority count", mn, 3);
        run_one(la);
        check_pair("majority", 2, 3, 0, 2, 2, 0);

        // tie between 1 and 3, class 1 owns rank 1
        tc = '{1, 3, 3, 1, 0}; td = '{5, 6, 7, 8, 9};
        ref_decode(pack_tc(), 5, mc, mn, mm);
        chk("model tie class", mc, 1);
        chk("model tie count", mn, 2);
        run_one(pack_tc());
        check_pair("tie", 1, 2, 0, 3, 2, 0);

        // empty slots at ranks 4,5 carry class 0 and must not vote
        tc = '{3, 1, 1, 0, 0}; td = '{1, 2, 3, 'h3FFFF, 'h3FFFF};
        run_one(pack_tc());
        check_pair("empty tail", 1, 2, 0, 1, 2, 0);

        // every slot empty
        tc = '{1, 2, 3, 1, 2}; td = '{'h3FFFF, 'h3FFFF, 'h3FFFF, 'h3FFFF, 'h3FFFF};
        ref_decode(pack_tc(), 5, mc, mn, mm);
        chk("model empty no_match", mm, 1);
        run_one(pack_tc());
        check_pair("all empty", 0, 0, 1, 0, 0, 1);

        // ranks 4,5 only matter for K=5
        tc = '{0, 2, 2, 1, 1}; td = '{11, 12, 13, 14, 15};
        ref_decode(pack_tc(), 3, mc, mn, mm);
        chk("model k3 class", mc, 2);
        run_one(pack_tc());
        check_pair("k3 window", 2, 2, 0, 2, 2, 0);

        // start while busy is ignored and the snapshot is isolated from list changes
        tc = '{2, 2, 1, 3, 2}; td = '{10, 20, 30, 40, 50};
        la = pack_tc();
        tc = '{0, 0, 0, 0, 0};
        lb = pack_tc();
        @(negedge clk);
        sorted_list = la;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        sorted_list = lb;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int n = 0; n < 20 && seen == 0; n++) begin
            @(posedge clk);
            #1;
            if (rv5) begin
                seen = 1;
                chk("busy-start class", int'(rc5), 2);
                chk("busy-start count", int'(vc5), 3);
            end
        end
        chk("busy-start result seen", seen, 1);
        repeat (8) @(posedge clk);

        // reset at E3 aborts the decode
        @(negedge clk);
        sorted_list = lb;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort busy", int'(b5), 0);
        chk("abort result_class", int'(rc5), 0);
        chk("abort vote_count", int'(vc5), 0);
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (rv5 || rv3) seen = 1;
        end
        chk("abort no result_valid", seen, 0);

        // randomized traffic: random starts, list churn, occasional reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 1) == 1) begin
                for (int r = 0; r < 5; r++) begin
                    tc[r] = int'($urandom_range(0, 3));
                    td[r] = ($urandom_range(0, 3) == 0) ? 'h3FFFF : int'($urandom_range(0, 1000));
                end
                sorted_list = pack_tc();
            end
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
